// File: rtl/ltc2387_rx_if.sv
// ltc2387_rx_if: ADC pins (CNV, burst clock, DCO/DA/DB) and downstream sample bus of ltc2387_rx.
interface ltc2387_rx_if #(parameter int ADC_WIDTH = 18);
    logic start, cnv, clk, dco, da, db, sample_valid, frame_err, busy;
    logic [ADC_WIDTH-1:0] sample;
    logic [15:0] pattern_err_cnt;
    modport master (input start, dco, da, db,
                    output cnv, clk, sample, sample_valid, frame_err, busy, pattern_err_cnt);
    modport slave  (output start, dco, da, db,
                    input cnv, clk, sample, sample_valid, frame_err, busy, pattern_err_cnt);
endinterface

// File: rtl/ltc2387_rx.sv
// ltc2387_rx: CNV/burst-clock controller and two-lane DDR receiver for an LTC2387-class ADC.
// Define LTC2387_RX_PATTERN_CHECK_EN to build the TEST_PATTERN mismatch counter.
module ltc2387_rx #(
    parameter int ADC_WIDTH  = 18,
    parameter int CNV_PERIOD = 64,
    parameter int CNV_HIGH   = 4,
    parameter int T_CONV     = 16,
    parameter int CLK_HALF   = 2,
    parameter int DRAIN_CYC  = 4
`ifdef LTC2387_RX_PATTERN_CHECK_EN
    , parameter logic [ADC_WIDTH-1:0] TEST_PATTERN = '1
`endif
) (
    input  logic fast_clk,
    input  logic reset,
    ltc2387_rx_if.master bus
);
    localparam int PAIRS = ADC_WIDTH / 2;
    localparam int PULSES = (PAIRS + 1) / 2;
    localparam int T_BURST_END = T_CONV + 2 * CLK_HALF * PULSES;
    localparam int T_RESULT = T_BURST_END + DRAIN_CYC;
    localparam int PW = $clog2(CNV_PERIOD);
    localparam int CW = $clog2(PAIRS + 1);

    typedef enum logic [2:0] {IDLE, CNV, WAIT_CONV, BURST, DRAIN, RESULT, HOLD} state_t;
    state_t state, next;
    logic [PW-1:0] pc, bp;
    logic [CW-1:0] cnt;
    logic [ADC_WIDTH-1:0] sr, smp;
    logic [2:0] s1, s2, dly;
    logic [4:0] o;
    logic tr, win, full, cnv_n, clk_n, sv_n, fe_n;

    always_ff @(posedge fast_clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            pc <= '0;
        end else begin
            state <= next;
            pc <= (state == IDLE || pc == PW'(CNV_PERIOD - 1)) ? '0 : pc + PW'(1);
        end

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = bus.start ? CNV : IDLE;
            CNV:       if (pc == PW'(CNV_HIGH - 1)) next = WAIT_CONV;
            WAIT_CONV: if (pc == PW'(T_CONV - 1)) next = BURST;
            BURST:     if (pc == PW'(T_BURST_END - 1)) next = DRAIN;
            DRAIN:     if (pc == PW'(T_RESULT - 1)) next = RESULT;
            RESULT:    next = HOLD;
            HOLD:      if (pc == PW'(CNV_PERIOD - 1)) next = bus.start ? CNV : IDLE;
            default:   next = IDLE;
        endcase
    end

    always_comb begin
        bp = pc - PW'(T_CONV);
        win = state inside {CNV, WAIT_CONV, BURST, DRAIN};
        full = cnt >= CW'(PAIRS);
        cnv_n = state == CNV;
        clk_n = state == BURST && (bp / PW'(CLK_HALF)) % PW'(2) == '0;
        sv_n = state == RESULT && full;
        fe_n = state == RESULT && !full;
    end

    // Pin-facing outputs are registered so the ADC never sees decode glitches.
    always_ff @(posedge fast_clk or posedge reset)
        if (reset) o <= '0;
        else o <= {cnv_n, clk_n, win, sv_n, fe_n};

    // dly holds the synced pair from the cycle before a DCO transition is seen.
    assign tr = s2[2] ^ dly[2];
    always_ff @(posedge fast_clk or posedge reset)
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            dly <= '0;
            sr <= '0;
            cnt <= '0;
            smp <= '0;
        end else begin
            s1 <= {bus.dco, bus.da, bus.db};
            s2 <= s1;
            dly <= s2;
            if (state == CNV && pc == '0) begin
                sr <= '0;
                cnt <= '0;
            end else if (tr && win && !full) begin
                sr <= {sr[ADC_WIDTH-3:0], dly[1:0]};
                cnt <= cnt + CW'(1);
            end
            if (sv_n) smp <= sr;
        end

    assign {bus.cnv, bus.clk, bus.busy, bus.sample_valid, bus.frame_err} = o;
    assign bus.sample = smp;

`ifdef LTC2387_RX_PATTERN_CHECK_EN
    logic [15:0] pec;
    always_ff @(posedge fast_clk or posedge reset)
        if (reset) pec <= '0;
        else if (sv_n && sr != TEST_PATTERN && pec != 16'hFFFF) pec <= pec + 16'd1;
    assign bus.pattern_err_cnt = pec;
`else
    assign bus.pattern_err_cnt = '0;
`endif
endmodule
